shift_arbiter: RTL and testbench

Shares the single 16-bit shift unit (`Shifter`: SLL 00, SRA 01, ROR 10) between two requesters, e.g. the execute-stage ALU and the load/store address path.
- Each requester talks to the block over a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin (or fixed priority), with one operation in flight and a registered operand stage.
- Throughput is one operation per cycle when responses are consumed immediately.

---
 rtl/shift_arbiter.sv | 121 ++++++++++++
 tb/tb_shift_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-port valid/ready arbiter in front of one 16-bit shifter (SLL/SRA/ROR).
// Optional macro SHIFT_ARB_ILLEGAL_MODE_EN adds `err` and passes mode 11 operands through unshifted.
module shift_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter bit FAIR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_amt,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req1_mode,
  output logic [15:0] rsp_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic        grant_id,
  output logic        busy
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
  ,
  output logic        err
`endif
);

  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both 1. Request ready never depends on the same port's valid being
  // held across cycles (no grant lock); response valid stays up until ready.

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam bit PTR_RESET = FAIR ? PRIO_INIT : 1'b0;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        grant_q;
  logic [15:0] op_in_q;
  logic [3:0]  op_amt_q;
  logic [1:0]  op_mode_q;

  logic        owner_ready;
  logic        window_open;
  logic        winner;
  logic        accept;

  function automatic logic [15:0] shift_op(input logic [15:0] din,
                                           input logic [3:0]  amt,
                                           input logic [1:0]  mode);
    logic [31:0] dbl;
    logic [15:0] res;
    dbl = {din, din} >> amt;
    case (mode)
      2'b00:   res = din << amt;
      2'b01:   res = $signed(din) >>> amt;
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
      2'b11:   res = din;
`endif
      default: res = dbl[15:0];
    endcase
    return res;
  endfunction

  always_comb begin
    owner_ready = grant_q ? rsp1_ready : rsp0_ready;
    window_open = (state_q == IDLE) || owner_ready;
    // Both valid: pointer decides; otherwise whichever port is valid.
    winner      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept      = window_open && (req0_valid || req1_valid);
    req0_ready  = accept && !winner;
    req1_ready  = accept && winner;

    state_d = state_q;
    if (accept)
      state_d = HOLD;
    else if ((state_q == HOLD) && owner_ready)
      state_d = IDLE;

    ptr_d = ptr_q;
    if (!FAIR)
      ptr_d = 1'b0;
    else if (accept)
      ptr_d = ~winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RESET;
      grant_q   <= 1'b0;
      op_in_q   <= '0;
      op_amt_q  <= '0;
      op_mode_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        grant_q   <= winner;
        op_in_q   <= winner ? req1_in   : req0_in;
        op_amt_q  <= winner ? req1_amt  : req0_amt;
        op_mode_q <= winner ? req1_mode : req0_mode;
      end
    end
  end

  assign busy       = (state_q == HOLD);
  assign grant_id   = grant_q;
  assign rsp0_valid = busy && !grant_q;
  assign rsp1_valid = busy && grant_q;
  assign rsp_data   = shift_op(op_in_q, op_amt_q, op_mode_q);

`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
  assign err = busy && (op_mode_q == 2'b11);
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: vector table, scoreboard on handshakes, and
// directed sequences for alternation, back-pressure and reset in HOLD.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_in = '0, req1_in = '0;
  logic [3:0]  req0_amt = '0, req1_amt = '0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, grant_id, busy;
  logic [15:0] rsp_data;
  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_grant_id, f_busy;
  logic [15:0] f_rsp_data;
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
  logic        err, f_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  shift_arbiter #(.PRIO_INIT(1'b0), .FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_amt(req0_amt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_amt(req1_amt), .req1_mode(req1_mode),
    .rsp_data(rsp_data), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .grant_id(grant_id), .busy(busy)
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
    , .err(err)
`endif
  );

  shift_arbiter #(.PRIO_INIT(1'b1), .FAIR(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_in(req0_in),
    .req0_amt(req0_amt), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_in(req1_in),
    .req1_amt(req1_amt), .req1_mode(req1_mode),
    .rsp_data(f_rsp_data), .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
    .grant_id(f_grant_id), .busy(f_busy)
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
    , .err(f_err)
`endif
  );

  // Reference shifter built one bit position at a time.
  function automatic logic [15:0] model(input logic [15:0] din, input logic [3:0] amt,
                                        input logic [1:0] mode);
    logic [15:0] r;
    r = din;
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
    if (mode == 2'b11) return din;
`endif
    for (int i = 0; i < 16; i++) begin
      if (i < int'(amt)) begin
        case (mode)
          2'b00:   r = {r[14:0], 1'b0};
          2'b01:   r = {r[15], r[15:1]};
          default: r = {r[0], r[15:1]};
        endcase
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: pop on response transfer, push on request transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {15'd0, rsp1_valid, rsp_data}, 32'h1ffff);
        else chk("sb_rsp", {15'd0, rsp1_valid, rsp_data}, {15'd0, exp_q.pop_front()});
      end
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, model(req0_in, req0_amt, req0_mode)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, model(req1_in, req1_amt, req1_mode)});
    end
  end

  task automatic drive(input logic port, input logic v, input logic [15:0] din,
                       input logic [3:0] amt, input logic [1:0] mode);
    if (port) begin
      req1_valid = v; req1_in = din; req1_amt = amt; req1_mode = mode;
    end else begin
      req0_valid = v; req0_in = din; req0_amt = amt; req0_mode = mode;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic port, input logic [15:0] din, input logic [3:0] amt,
                       input logic [1:0] mode, input logic [15:0] exp);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(port, 1'b1, din, amt, mode);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin got = 1'b1; break; end
    end
    chk("accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, din, amt, mode);
    @(negedge clk);
    chk("op_busy", {31'd0, busy}, 32'd1);
    chk("op_grant", {31'd0, grant_id}, {31'd0, port});
    chk("op_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
    chk("op_data", {16'd0, rsp_data}, {16'd0, exp});
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
    chk("op_err", {31'd0, err}, {31'd0, mode == 2'b11});
`endif
    @(negedge clk);
    chk("op_idle", {30'd0, busy, rsp0_valid | rsp1_valid}, 32'd0);
  endtask

  task automatic reset_mid_hold(input logic port);
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive(port, 1'b1, 16'h1357, 4'd5, 2'b10);
    @(negedge clk);
    chk("rmh_accept", {30'd0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, 16'h0, 4'd0, 2'b00);
    @(negedge clk);
    chk("rmh_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rmh_outs", {27'd0, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 32'd0);
    chk("rmh_data", {16'd0, rsp_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmh_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h0001, 4'd1, 2'b00);
    drive(1'b1, 1'b1, 16'h0001, 4'd2, 2'b00);
    @(negedge clk);
    chk("rmh_ptr_init", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic        port;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic        exp_w;
    logic        prev_w;
    logic [15:0] f_exp;
    logic [15:0] hold_exp;
    vecs[0] = '{1'b0, 16'h8001, 4'd1,  2'b00, 16'h0002};
    vecs[1] = '{1'b1, 16'h8000, 4'd4,  2'b01, 16'hF800};
    vecs[2] = '{1'b1, 16'h1234, 4'd4,  2'b10, 16'h4123};
    vecs[3] = '{1'b1, 16'h1234, 4'd0,  2'b10, 16'h1234};
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
    vecs[4] = '{1'b0, 16'hABCD, 4'd3,  2'b11, 16'hABCD};
`else
    vecs[4] = '{1'b0, 16'hABCD, 4'd3,  2'b11, 16'hB579};
`endif
    vecs[5] = '{1'b0, 16'hFFFF, 4'd15, 2'b00, 16'h8000};
    vecs[6] = '{1'b1, 16'h8000, 4'd15, 2'b01, 16'hFFFF};
    vecs[7] = '{1'b0, 16'h0001, 4'd15, 2'b10, 16'h0002};
    vecs[8] = '{1'b1, 16'h4000, 4'd15, 2'b01, 16'h0000};

    // Reset values
    @(negedge clk);
    chk("rst_ctrl", {27'd0, busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 32'd0);
    chk("rst_grant_data", {15'd0, grant_id, rsp_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].port, vecs[i].din, vecs[i].amt, vecs[i].mode, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      logic        p;
      logic [15:0] d;
      logic [3:0]  a;
      logic [1:0]  m;
      p = 1'($urandom_range(0, 1));
      d = 16'($urandom_range(0, 16'hFFFF));
      a = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      do_op(p, d, a, m, model(d, a, m));
    end

    // Both ports always valid: round-robin alternates, fixed priority starves port 1.
    do_reset();
    exp_w = 1'b0;
    prev_w = 1'b0;
    f_exp = '0;
    drive(1'b0, 1'b1, 16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
    drive(1'b1, 1'b1, 16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", {30'd0, req1_ready, req0_ready}, exp_w ? 32'd2 : 32'd1);
      chk("fix_grant", {30'd0, f_req1_ready, f_req0_ready}, 32'd1);
      if (i > 0) begin
        chk("rr_owner", {31'd0, grant_id}, {31'd0, prev_w});
        chk("fix_rsp", {14'd0, f_rsp1_valid, f_rsp0_valid, f_rsp_data}, {16'd1, f_exp});
        chk("fix_owner", {30'd0, f_grant_id, f_busy}, 32'd1);
`ifdef SHIFT_ARB_ILLEGAL_MODE_EN
        chk("fix_err", {31'd0, f_err}, 32'd0);
`endif
      end
      f_exp = model(req0_in, req0_amt, req0_mode);
      prev_w = exp_w;
      exp_w = ~exp_w;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
      drive(1'b1, 1'b1, 16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Back-pressure on port 0 while port 1 waits
    do_reset();
    hold_exp = model(16'h00F0, 4'd2, 2'b00);
    drive(1'b0, 1'b1, 16'h00F0, 4'd2, 2'b00);
    @(negedge clk);
    chk("bp_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rsp0_ready = 1'b0;
    drive(1'b1, 1'b1, 16'h00FF, 4'd4, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_rsp", {15'd0, rsp0_valid, rsp_data}, {15'd0, 1'b1, hold_exp});
      chk("bp_no_accept", {29'd0, req0_ready, req1_ready, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_p1_rsp", {14'd0, rsp1_valid, grant_id, rsp_data}, {16'h0003, 16'h000F});
    @(negedge clk);
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // Reset while holding an operation
    reset_mid_hold(1'b1);
    reset_mid_hold(1'b0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
